cap_err_chk: RTL and testbench

//  Consumer side of capability-error injection: takes one record per injected LSU error, watches
//  the cheri_ex LSU request and the core trap, and checks each injection produced the correct fault.

---
 rtl/cap_err_chk.sv | 169 ++++++++++++++++
 tb/tb_cap_err_chk.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cap_err_chk.sv
// Checks each injected LSU capability error against the fault the core actually traps on.
// Emits one-cycle registered pass/fail pulses with a reason code and keeps saturating counters.
module cap_err_chk #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inj_valid,
    input  logic [7:0]       inj_flag,
    input  logic             inj_is_cap,
    input  logic             inj_we,
    input  logic             lsu_req,
    input  logic             lsu_cheri_err,
    input  logic             exc_valid,
    input  logic [5:0]       exc_mcause,
    input  logic [4:0]       exc_cheri_cause,
    output logic             chk_pass,
    output logic             chk_fail,
    output logic [2:0]       fail_code,
    output logic [CNT_W-1:0] pass_cnt,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [CNT_W-1:0] skip_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_REQ, WAIT_EXC} state_t;

    state_t     state, state_n;
    logic [TMR_W-1:0] timer, timer_n;
    logic [2:0] rec_type;
    logic       rec_we;
    logic       rec_cap;

    logic       new_inj, new_skip, new_illegal, latch;
    logic       fire_pass, fire_fail;
    logic [2:0] code;
    logic       unused_flag_bits;

    // Address-modified bit and spare type bits do not influence the expected fault.
    assign unused_flag_bits = ^inj_flag[6:3];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    function automatic logic fault_match(input logic [2:0] t, input logic we, input logic cap,
                                         input logic [5:0] mc, input logic [4:0] cc);
        logic ok;
        ok = 1'b0;
        case (t)
            3'd0: ok = (mc == 6'd28) && (cc == 5'h02);
            3'd1: ok = (mc == 6'd28) && (cc == 5'h03);
            3'd3: ok = (mc == 6'd28) && (cc == 5'h01);
            3'd2: begin
                if (!we)
                    ok = (mc == 6'd28) && (cc == 5'h12);
                else if (cap)
                    ok = (mc == 6'd28) && ((cc == 5'h13) || (cc == 5'h15));
                else
                    ok = (mc == 6'd28) && (cc == 5'h13);
            end
            3'd4:    ok = (mc == (we ? 6'd6 : 6'd4));
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        fire_pass   = 1'b0;
        fire_fail   = 1'b0;
        code        = 3'd0;
        latch       = 1'b0;
        new_skip    = inj_valid && inj_flag[7];
        new_inj     = inj_valid && !inj_flag[7];
        new_illegal = (inj_flag[2:0] > 3'd4) || ((inj_flag[2:0] == 3'd4) && !inj_is_cap);

        case (state)
            WAIT_REQ: begin
                // Alignment faults never raise lsu_cheri_err, so any request advances them.
                if (lsu_req) begin
                    if (lsu_cheri_err || (rec_type == 3'd4)) begin
                        state_n = WAIT_EXC;
                        timer_n = '0;
                    end else begin
                        fire_fail = 1'b1;
                        code      = 3'd1;
                        state_n   = IDLE;
                    end
                end else if (exc_valid) begin
                    fire_fail = 1'b1;
                    code      = 3'd2;
                    state_n   = IDLE;
                end
            end
            WAIT_EXC: begin
                timer_n = timer + 1'b1;
                if (exc_valid) begin
                    if (fault_match(rec_type, rec_we, rec_cap, exc_mcause, exc_cheri_cause))
                        fire_pass = 1'b1;
                    else begin
                        fire_fail = 1'b1;
                        code      = 3'd3;
                    end
                    state_n = IDLE;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    fire_fail = 1'b1;
                    code      = 3'd4;
                    state_n   = IDLE;
                end
            end
            default: ;
        endcase

        // A new record overrides whatever the pending one was doing this cycle.
        if (new_inj) begin
            if ((state != IDLE) && !fire_pass && !fire_fail) begin
                fire_fail = 1'b1;
                code      = 3'd6;
            end
            if (new_illegal) begin
                if (!fire_pass && !fire_fail) begin
                    fire_fail = 1'b1;
                    code      = 3'd5;
                end
                state_n = IDLE;
            end else begin
                latch   = 1'b1;
                state_n = WAIT_REQ;
            end
        end
    end

    // Registered control and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            chk_pass  <= 1'b0;
            chk_fail  <= 1'b0;
            fail_code <= 3'd0;
            pass_cnt  <= '0;
            fail_cnt  <= '0;
            skip_cnt  <= '0;
        end else begin
            state     <= state_n;
            timer     <= timer_n;
            chk_pass  <= fire_pass;
            chk_fail  <= fire_fail;
            fail_code <= fire_fail ? code : 3'd0;
            pass_cnt  <= sat_inc(pass_cnt, fire_pass);
            fail_cnt  <= sat_inc(fail_cnt, fire_fail);
            skip_cnt  <= sat_inc(skip_cnt, new_skip);
        end
    end

    // Latched record (data only, no reset)
    always_ff @(posedge clk) begin
        if (latch) begin
            rec_type <= inj_flag[2:0];
            rec_we   <= inj_we;
            rec_cap  <= inj_is_cap;
        end
    end

endmodule

// File: tb/tb_cap_err_chk.sv
// Directed bench for cap_err_chk: hand-computed pass/fail pulses, reason codes and counters.
module tb_cap_err_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic        inj_valid;
    logic [7:0]  inj_flag;
    logic        inj_is_cap;
    logic        inj_we;
    logic        lsu_req;
    logic        lsu_cheri_err;
    logic        exc_valid;
    logic [5:0]  exc_mcause;
    logic [4:0]  exc_cheri_cause;
    logic        chk_pass;
    logic        chk_fail;
    logic [2:0]  fail_code;
    logic [15:0] pass_cnt;
    logic [15:0] fail_cnt;
    logic [15:0] skip_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    cap_err_chk #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .inj_valid(inj_valid), .inj_flag(inj_flag), .inj_is_cap(inj_is_cap), .inj_we(inj_we),
        .lsu_req(lsu_req), .lsu_cheri_err(lsu_cheri_err),
        .exc_valid(exc_valid), .exc_mcause(exc_mcause), .exc_cheri_cause(exc_cheri_cause),
        .chk_pass(chk_pass), .chk_fail(chk_fail), .fail_code(fail_code),
        .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .skip_cnt(skip_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        inj_valid       = 1'b0;
        inj_flag        = 8'h00;
        inj_is_cap      = 1'b0;
        inj_we          = 1'b0;
        lsu_req         = 1'b0;
        lsu_cheri_err   = 1'b0;
        exc_valid       = 1'b0;
        exc_mcause      = 6'd0;
        exc_cheri_cause = 5'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inj(input logic [7:0] flag, input logic cap, input logic we);
        inj_valid = 1'b1; inj_flag = flag; inj_is_cap = cap; inj_we = we;
        tick();
        clear_inputs();
    endtask

    task automatic req(input logic err);
        lsu_req = 1'b1; lsu_cheri_err = err;
        tick();
        clear_inputs();
    endtask

    task automatic exc(input logic [5:0] mc, input logic [4:0] cc);
        exc_valid = 1'b1; exc_mcause = mc; exc_cheri_cause = cc;
        tick();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        tick();
        tick();
        check("rst_pass", chk_pass, 0);
        check("rst_fail", chk_fail, 0);
        check("rst_code", fail_code, 0);
        check("rst_cnts", {pass_cnt, fail_cnt} | skip_cnt, 0);
        rst = 1'b0;
        tick();

        // tag load: exception 3 cycles after the request
        inj(8'h00, 1'b0, 1'b0);
        check("tag_inj_nopulse", {chk_pass, chk_fail}, 0);
        req(1'b1);
        tick();
        tick();
        exc(6'd28, 5'h02);
        check("tag_pass", chk_pass, 1);
        check("tag_nofail", chk_fail, 0);
        check("tag_pass_cnt", pass_cnt, 1);
        tick();
        check("tag_pulse_width", chk_pass, 0);

        // permission store on CSC: 0x15 accepted, 0x12 rejected
        inj(8'h02, 1'b1, 1'b1);
        req(1'b1);
        exc(6'd28, 5'h15);
        check("perm_pass", chk_pass, 1);
        check("perm_pass_cnt", pass_cnt, 2);
        inj(8'h02, 1'b1, 1'b1);
        req(1'b1);
        exc(6'd28, 5'h12);
        check("perm_bad_fail", chk_fail, 1);
        check("perm_bad_code", fail_code, 3);
        check("perm_bad_cnt", fail_cnt, 1);

        // bounds with error not flagged on the request
        inj(8'h03, 1'b0, 1'b0);
        req(1'b0);
        check("miss_fail", chk_fail, 1);
        check("miss_code", fail_code, 1);
        check("miss_cnt", fail_cnt, 2);
        tick();
        check("miss_pulse_width", chk_fail, 0);

        // seal with no exception: fail on the 64th edge after the request edge
        inj(8'h01, 1'b0, 1'b0);
        req(1'b1);
        for (int i = 0; i < 63; i++) tick();
        check("tmo_not_yet", chk_fail, 0);
        tick();
        check("tmo_fail", chk_fail, 1);
        check("tmo_code", fail_code, 4);
        check("tmo_cnt", fail_cnt, 3);

        // skip record
        inj(8'h80, 1'b0, 1'b0);
        check("skip_cnt", skip_cnt, 1);
        check("skip_nopulse", {chk_pass, chk_fail}, 0);

        // RV32 alignment record is illegal
        inj(8'h04, 1'b0, 1'b0);
        check("illegal_fail", chk_fail, 1);
        check("illegal_code", fail_code, 5);
        check("illegal_cnt", fail_cnt, 4);

        // overrun: second record 2 cycles after first, then second record passes
        inj(8'h00, 1'b0, 1'b0);
        tick();
        inj(8'h00, 1'b0, 1'b0);
        check("ovr_fail", chk_fail, 1);
        check("ovr_code", fail_code, 6);
        check("ovr_cnt", fail_cnt, 5);
        req(1'b1);
        exc(6'd28, 5'h02);
        check("ovr_second_pass", chk_pass, 1);
        check("ovr_pass_cnt", pass_cnt, 3);

        // CSC alignment store: request without cheri_err still advances, mcause 6
        inj(8'h04, 1'b1, 1'b1);
        req(1'b0);
        check("align_no_miss", chk_fail, 0);
        exc(6'd6, 5'h1f);
        check("align_pass", chk_pass, 1);
        check("align_pass_cnt", pass_cnt, 4);

        // exception before any request
        inj(8'h00, 1'b0, 1'b0);
        exc(6'd28, 5'h02);
        check("early_exc_fail", chk_fail, 1);
        check("early_exc_code", fail_code, 2);
        check("early_exc_cnt", fail_cnt, 6);

        // reset while waiting for the exception
        inj(8'h01, 1'b0, 1'b0);
        req(1'b1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_nopulse", {chk_pass, chk_fail}, 0);
        check("midrst_pass_cnt", pass_cnt, 0);
        check("midrst_fail_cnt", fail_cnt, 0);
        check("midrst_skip_cnt", skip_cnt, 0);
        tick();
        check("midrst_quiet", {chk_pass, chk_fail}, 0);
        inj(8'h03, 1'b1, 1'b0);
        req(1'b1);
        exc(6'd28, 5'h01);
        check("post_rst_pass", chk_pass, 1);
        check("post_rst_cnt", pass_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
